pio_poll_master: RTL

Avalon-MM master that periodically reads the data register of an input PIO slave, such as the slider or switch PIOs in the QSYS system. It debounces the sampled value and presents a stable copy to fabric logic, with a one-cycle change strobe and a changed-bit mask. It lets MLP control logic consume PIO inputs without Nios involvement. It initiates one single-word read at a time.

---
 rtl/pio_poll_if.sv | 20 ++
 rtl/pio_poll_master.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pio_poll_if.sv
// Avalon-MM read-only bus between the PIO poller and an input PIO slave.
interface pio_poll_if #(
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_read,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );
endinterface

// File: rtl/pio_poll_master.sv
// Periodically reads a PIO data register over Avalon-MM, debounces the sample and
// publishes a stable value with a one-cycle change strobe and changed-bit mask.
module pio_poll_master #(
  parameter int DATA_W       = 10,
  parameter int ADDR_W       = 2,
  parameter int TARGET_ADDR  = 0,
  parameter int PERIOD       = 50000,
  parameter int STABLE_COUNT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  pio_poll_if.master        avm,
  input  logic              poll_enable,
  output logic [DATA_W-1:0] value,
  output logic              value_valid,
  output logic              change_pulse,
  output logic [DATA_W-1:0] changed_bits,
  output logic              timeout_err,
  output logic              overrun,
  input  logic              err_clear
);

  localparam int TMR_W = $clog2(PERIOD);
  localparam int STB_W = $clog2(STABLE_COUNT + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(PERIOD - 1);
  localparam logic [STB_W-1:0]  STB_MAX  = STB_W'(STABLE_COUNT);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] TGT      = ADDR_W'(TARGET_ADDR);

  typedef enum logic [1:0] {IDLE, WAIT_TICK, REQ, WAIT_DATA} state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [TO_W-1:0]   to_cnt;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] candidate;
  logic [STB_W-1:0]  stb_cnt;
  logic [STB_W-1:0]  stb_next;
  logic [DATA_W-1:0] sample;
  logic              tick;
  logic              sample_stb;
  logic              accept;
  logic              set_to;
  logic              set_ov;

  assign avm.avm_read    = rd_q;
  assign avm.avm_address = addr_q;

  assign sample     = avm.avm_readdata[DATA_W-1:0];
  assign tick       = poll_enable && (timer == '0);
  assign sample_stb = (state == WAIT_DATA) && avm.avm_readdatavalid;
  assign set_to     = (state == WAIT_DATA) && !avm.avm_readdatavalid && (to_cnt == TO_LAST);
  // A tick while a read is still in flight is dropped, never queued.
  assign set_ov     = tick && ((state == REQ) || (state == WAIT_DATA));

  generate
    if (DATA_W < 32) begin : g_hi
      logic unused_rd_hi;
      assign unused_rd_hi = &{1'b0, avm.avm_readdata[31:DATA_W]};
    end
  endgenerate

  always_comb begin
    stb_next = STB_W'(1);
    if (sample == candidate) begin
      stb_next = (stb_cnt == STB_MAX) ? stb_cnt : stb_cnt + STB_W'(1);
    end
  end

  assign accept = sample_stb && (stb_next == STB_MAX) && (!value_valid || (sample != value));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (!poll_enable || tick) begin
      timer <= TMR_LOAD;
    end else begin
      timer <= timer - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rd_q   <= 1'b0;
      addr_q <= '0;
      to_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (poll_enable) state <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (!poll_enable) begin
            state <= IDLE;
          end else if (tick) begin
            state  <= REQ;
            rd_q   <= 1'b1;
            addr_q <= TGT;
          end
        end
        // A stalled read cannot be withdrawn, so poll_enable is ignored here.
        REQ: begin
          if (!avm.avm_waitrequest) begin
            state  <= WAIT_DATA;
            rd_q   <= 1'b0;
            addr_q <= '0;
            to_cnt <= '0;
          end
        end
        WAIT_DATA: begin
          if (avm.avm_readdatavalid || (to_cnt == TO_LAST)) begin
            state <= poll_enable ? WAIT_TICK : IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else if (err_clear) begin
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (set_to) timeout_err <= 1'b1;
      if (set_ov) overrun     <= 1'b1;
    end
  end

  // The candidate always becomes the latest sample, so acceptance publishes the sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate    <= '0;
      stb_cnt      <= '0;
      value        <= '0;
      value_valid  <= 1'b0;
      changed_bits <= '0;
      change_pulse <= 1'b0;
    end else begin
      change_pulse <= accept;
      if (sample_stb) begin
        candidate <= sample;
        stb_cnt   <= stb_next;
      end
      if (accept) begin
        value        <= sample;
        value_valid  <= 1'b1;
        changed_bits <= value ^ sample;
      end
    end
  end

endmodule
